// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: arbitrates memory waits,
// EX redirects and load-use hazards, and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    output logic             pc_load,
    output logic             pc_redirect,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             i_hold,
    output logic             d_hold,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    logic             i_done_q, i_done_d;
    logic             d_done_q, d_done_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic i_ok, d_ok, mem_stall, lu_hazard, redirect_take;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign i_ok      = ~i_req | imem_resp | i_done_q;
    assign d_ok      = ~dmem_req | dmem_resp | d_done_q;
    assign mem_stall = ~(i_ok & d_ok);
    assign lu_hazard = ex_mem_read & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // A redirect only applies on an advancing cycle; while frozen EX keeps it asserted.
    assign redirect_take = ~rst & ~mem_stall & ex_redirect;

    always_comb begin
        pc_load     = 1'b0;
        pc_redirect = 1'b0;
        if_id_load  = 1'b0;
        id_ex_load  = 1'b0;
        ex_mem_load = 1'b0;
        mem_wb_load = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!rst && !mem_stall) begin
            if (ex_redirect) begin
                pc_load     = 1'b1;
                pc_redirect = 1'b1;
                if_id_load  = 1'b1;
                id_ex_load  = 1'b1;
                ex_mem_load = 1'b1;
                mem_wb_load = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu_hazard) begin
                id_ex_load  = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_load = 1'b1;
                mem_wb_load = 1'b1;
            end else begin
                pc_load     = 1'b1;
                if_id_load  = 1'b1;
                id_ex_load  = 1'b1;
                ex_mem_load = 1'b1;
                mem_wb_load = 1'b1;
            end
        end
    end

    always_comb begin
        i_done_d = 1'b0;
        d_done_d = 1'b0;
        if (mem_stall) begin
            i_done_d = i_done_q | (i_req & imem_resp);
            d_done_d = d_done_q | (dmem_req & dmem_resp);
        end
        stall_d = pc_load ? stall_q : sat_inc(stall_q);
        flush_d = redirect_take ? sat_inc(flush_q) : flush_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign i_hold       = i_done_q & ~rst;
    assign d_hold       = d_done_q & ~rst;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; narrow counters make saturation reachable.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam logic [7:0] FRZ = 8'h00;
    localparam logic [7:0] ADV = 8'hBC;
    localparam logic [7:0] RED = 8'hFF;
    localparam logic [7:0] LU  = 8'h1D;

    logic clk = 1'b0;
    logic rst;
    logic i_req, imem_resp, dmem_req, dmem_resp;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic ex_mem_read, ex_redirect;
    logic pc_load, pc_redirect, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic if_id_flush, id_ex_flush, i_hold, d_hold;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [7:0] ctrl;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign ctrl = {pc_load, pc_redirect, if_id_load, id_ex_load,
                   ex_mem_load, mem_wb_load, if_id_flush, id_ex_flush};

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .pc_load(pc_load), .pc_redirect(pc_redirect),
        .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .i_hold(i_hold), .d_hold(d_hold),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_mem_read = 0; ex_redirect = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'(FRZ));
        chk("rst_hold", 32'({i_hold, d_hold}), 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        chk("rst_flush", 32'(flush_count), 32'd0);
        rst = 0;
        #1;

        for (int i = 0; i < 10; i++) begin
            chk("nohaz_ctrl", 32'(ctrl), 32'(ADV));
            tick();
        end
        chk("nohaz_stall", 32'(stall_cycles), 32'd0);
        chk("nohaz_flush", 32'(flush_count), 32'd0);

        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5;
        #1;
        chk("lu_ctrl", 32'(ctrl), 32'(LU));
        tick();
        idle_inputs();
        chk("lu_stall", 32'(stall_cycles), 32'd1);
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        #1;
        chk("lu_x0_ctrl", 32'(ctrl), 32'(ADV));
        tick();
        idle_inputs();
        chk("lu_x0_stall", 32'(stall_cycles), 32'd1);

        // Split responses: imem in cycle 2, dmem in cycle 5.
        i_req = 1; dmem_req = 1;
        for (int c = 1; c <= 5; c++) begin
            imem_resp = (c == 2);
            dmem_resp = (c == 5);
            #1;
            chk("split_ctrl", 32'(ctrl), (c == 5) ? 32'(ADV) : 32'(FRZ));
            chk("split_ihold", 32'(i_hold), (c >= 3) ? 32'd1 : 32'd0);
            chk("split_dhold", 32'(d_hold), 32'd0);
            tick();
        end
        idle_inputs();
        #1;
        chk("split_done_clr", 32'({i_hold, d_hold}), 32'd0);
        chk("split_stall", 32'(stall_cycles), 32'd5);

        dmem_req = 1; ex_redirect = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("dmiss_red_wait", 32'(ctrl), 32'(FRZ));
            tick();
        end
        dmem_resp = 1;
        #1;
        chk("dmiss_red_adv", 32'(ctrl), 32'(RED));
        tick();
        idle_inputs();
        chk("dmiss_red_flush", 32'(flush_count), 32'd1);
        chk("dmiss_red_stall", 32'(stall_cycles), 32'd8);

        ex_redirect = 1; ex_mem_read = 1; ex_rd = 7; id_rs1 = 7;
        #1;
        chk("red_lu_ctrl", 32'(ctrl), 32'(RED));
        tick();
        idle_inputs();
        chk("red_lu_stall", 32'(stall_cycles), 32'd8);
        chk("red_lu_flush", 32'(flush_count), 32'd2);

        i_req = 1; dmem_req = 1; imem_resp = 1;
        tick();
        imem_resp = 0;
        #1;
        chk("mid_ihold", 32'(i_hold), 32'd1);
        chk("mid_stall", 32'(stall_cycles), 32'd9);
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("rstmid_ihold", 32'(i_hold), 32'd0);
        chk("rstmid_stall", 32'(stall_cycles), 32'd0);
        chk("rstmid_flush", 32'(flush_count), 32'd0);
        chk("rstmid_ctrl", 32'(ctrl), 32'(FRZ));

        i_req = 0; dmem_req = 1;
        repeat (14) tick();
        chk("sat_pre", 32'(stall_cycles), 32'd14);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("sat_hold", 32'(stall_cycles), 32'd15);
        end
        idle_inputs();
        #1;
        chk("sat_adv_ctrl", 32'(ctrl), 32'(ADV));
        tick();
        chk("sat_final", 32'(stall_cycles), 32'd15);

        ex_redirect = 1;
        repeat (20) tick();
        idle_inputs();
        chk("flush_sat", 32'(flush_count), 32'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
